// File: rtl/traffic_controller.sv
// Two-road intersection sequencer with a pedestrian walk phase.
// Phase timing is counted in divider ticks; the FSM itself runs on every i_clkin.
//
//  state | meaning
//  ------+------------------------------------------------
//  MG    | main green, side red; holds until a request is pending
//  MY    | main yellow, side red
//  AR1   | all red clearance before side green or walk
//  SG    | side green, main red
//  SY    | side yellow, main red
//  WK    | pedestrian walk, all red
//  AR2   | all red clearance before returning to main green
module traffic_controller #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 4
) (
    input  logic       i_clkin,
    input  logic       i_clear,
    input  logic       i_tick,
    input  logic       i_sensor_b,
    input  logic       i_ped_req,
    output logic [2:0] o_main_light,
    output logic [2:0] o_side_light,
    output logic       o_walk,
    output logic       o_ped_ack,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_MG  = 3'd0,
        S_MY  = 3'd1,
        S_AR1 = 3'd2,
        S_SG  = 3'd3,
        S_SY  = 3'd4,
        S_WK  = 3'd5,
        S_AR2 = 3'd6,
        S_BAD = 3'd7
    } state_t;

    localparam logic [7:0] L_GREEN  = 8'(GREEN_TICKS - 1);
    localparam logic [7:0] L_YELLOW = 8'(YELLOW_TICKS - 1);
    localparam logic [7:0] L_ALLRED = 8'(ALLRED_TICKS - 1);
    localparam logic [7:0] L_WALK   = 8'(WALK_TICKS - 1);

    localparam logic [2:0] C_RED    = 3'b100;
    localparam logic [2:0] C_YELLOW = 3'b010;
    localparam logic [2:0] C_GREEN  = 3'b001;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;
    logic       r_ped_pend;
    logic       r_side_pend;
    logic       r_ped_ack;
    logic       w_ped_nxt;
    logic       w_side_nxt;
    logic       w_expired;
    logic       w_enter_wk;
    logic       w_enter_sg;

    function automatic logic [7:0] f_load(input state_t s);
        logic [7:0] v;
        v = L_GREEN;
        case (s)
            S_MY, S_SY:   v = L_YELLOW;
            S_AR1, S_AR2: v = L_ALLRED;
            S_WK:         v = L_WALK;
            default:      v = L_GREEN;
        endcase
        return v;
    endfunction

    assign w_expired = i_tick && (r_timer == 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_MG:    if (w_expired && (r_ped_pend || r_side_pend)) w_state_nxt = S_MY;
            S_MY:    if (w_expired) w_state_nxt = S_AR1;
            S_AR1:   if (w_expired) w_state_nxt = r_ped_pend ? S_WK : S_SG;
            S_SG:    if (w_expired) w_state_nxt = S_SY;
            S_SY:    if (w_expired) w_state_nxt = S_AR2;
            S_WK:    if (w_expired) w_state_nxt = S_AR2;
            S_AR2:   if (w_expired) w_state_nxt = S_MG;
            default: w_state_nxt = S_MG;
        endcase
    end

    // MG with no request parks the timer at 0, so the first tick after a request leaves.
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_state_nxt != r_state) begin
            w_timer_nxt = f_load(w_state_nxt);
        end else if (i_tick && (r_timer != 8'd0)) begin
            w_timer_nxt = r_timer - 8'd1;
        end
    end

    assign w_enter_wk = (w_state_nxt == S_WK) && (r_state != S_WK);
    assign w_enter_sg = (w_state_nxt == S_SG) && (r_state != S_SG);

    // Requests arriving on the clock that enters their service state are absorbed.
    always_comb begin
        w_ped_nxt = r_ped_pend;
        if (w_enter_wk) begin
            w_ped_nxt = 1'b0;
        end else if (i_ped_req && (r_state != S_WK)) begin
            w_ped_nxt = 1'b1;
        end

        w_side_nxt = r_side_pend;
        if (w_enter_sg) begin
            w_side_nxt = 1'b0;
        end else if (i_sensor_b && (r_state != S_SG)) begin
            w_side_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clkin) begin
        if (i_clear) begin
            r_state     <= S_MG;
            r_timer     <= L_GREEN;
            r_ped_pend  <= 1'b0;
            r_side_pend <= 1'b0;
            r_ped_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_ped_pend  <= w_ped_nxt;
            r_side_pend <= w_side_nxt;
            r_ped_ack   <= w_ped_nxt && !r_ped_pend;
        end
    end

    always_comb begin
        o_main_light = C_RED;
        o_side_light = C_RED;
        o_walk       = 1'b0;
        case (r_state)
            S_MG:    o_main_light = C_GREEN;
            S_MY:    o_main_light = C_YELLOW;
            S_SG:    o_side_light = C_GREEN;
            S_SY:    o_side_light = C_YELLOW;
            S_WK:    o_walk       = 1'b1;
            default: o_walk       = 1'b0;
        endcase
    end

    assign o_state   = r_state;
    assign o_ped_ack = r_ped_ack;

endmodule
